// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// Imported by the interface, the latency counter user and the top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int MEM_LAT_DEF    = 4;
  localparam int STARVE_MAX_DEF = 3;

  // Data wins unless fetch is waiting and the data streak is used up.
  function automatic logic pick_grant(
    input logic if_req,
    input logic d_req,
    input logic starved
  );
    return (d_req && !(if_req && starved)) ? GNT_D : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between requesters, arbiter and the unified memory.
// slave is the arbiter's view, master is the surrounding system's.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_ack,
    output if_rdata,
    input  d_req,
    input  d_wr,
    input  d_addr,
    input  d_wdata,
    output d_ack,
    output d_rdata,
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_ack,
    input  if_rdata,
    output d_req,
    output d_wr,
    output d_addr,
    output d_wdata,
    input  d_ack,
    input  d_rdata,
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter; done flags the last cycle of a wait.
// Also intended for cache-fill latency tracking.
module mem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one access at a time through
// IDLE -> ISSUE -> WAIT -> RESP, data first with a fetch guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] LAT_LOAD =
    CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX =
    STK_W'(STARVE_MAX);

  state_t state;
  state_t state_nx;

  logic              gnt;
  logic              gnt_nx;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STK_W-1:0]  streak;
  logic [STK_W-1:0]  streak_nx;

  logic any_req;
  logic grab;
  logic starved;
  logic lat_done;

  assign any_req = bus.if_req | bus.d_req;
  assign grab    = (state == IDLE) & any_req;
  assign starved = (streak == STK_MAX);
  assign gnt_nx  = pick_grant(bus.if_req, bus.d_req, starved);

  // Streak counts data grants that overtook a waiting fetch.
  always_comb begin
    streak_nx = '0;
    if (gnt_nx == GNT_D && bus.if_req) begin
      streak_nx = starved ? streak : streak + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (lat_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= GNT_IF;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      streak  <= '0;
    end else if (grab) begin
      gnt     <= gnt_nx;
      wr_q    <= (gnt_nx == GNT_D) & bus.d_wr;
      addr_q  <= (gnt_nx == GNT_D) ? bus.d_addr
                                   : bus.if_addr;
      wdata_q <= (gnt_nx == GNT_D) ? bus.d_wdata
                                   : '0;
      streak  <= streak_nx;
    end
  end

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ISSUE),
    .load_val (LAT_LOAD),
    .dec      (state == WAIT),
    .done     (lat_done)
  );

  always_comb begin
    bus.mem_en   = 1'b0;
    bus.if_ack   = 1'b0;
    bus.d_ack    = 1'b0;
    bus.if_rdata = '0;
    bus.d_rdata  = '0;
    bus.busy     = (state != IDLE);
    unique case (1'b1)
      (state == ISSUE): begin
        bus.mem_en = 1'b1;
      end
      (state == RESP && gnt == GNT_IF): begin
        bus.if_ack   = 1'b1;
        bus.if_rdata = bus.mem_rdata;
      end
      (state == RESP && gnt == GNT_D): begin
        bus.d_ack = 1'b1;
        if (!wr_q) bus.d_rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  a_ack_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.if_ack && bus.d_ack)
  );

  a_en_once: assert property (
    @(posedge clk) disable iff (rst)
    bus.mem_en |=> !bus.mem_en
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic against a transaction-timing model
// of the arbiter, with a fixed-latency memory behind it.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int SM = 3;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_LAT    (L),
    .STARVE_MAX (SM)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    logic [7:0] b;
    b = ~a;
    return (a == 8'h10) ? 16'hA5A5 : ({a, b} ^ 16'h3C3C);
  endfunction

  // memory: writes land at the issue edge, reads appear L cycles on
  logic [DW-1:0] mem   [256];
  bit            mem_w [256];
  logic [DW-1:0] pipe  [L];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) begin
      mem[bus.mem_addr[7:0]]   <= bus.mem_wdata;
      mem_w[bus.mem_addr[7:0]] <= 1'b1;
    end
    if (!bus.mem_en)
      pipe[0] <= DW'($urandom);
    else if (mem_w[bus.mem_addr[7:0]])
      pipe[0] <= mem[bus.mem_addr[7:0]];
    else
      pipe[0] <= init_word(bus.mem_addr[7:0]);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mem_rdata = pipe[L-1];

  // reference model state
  logic [DW-1:0] ref_mem [256];
  int            cyc;
  bit            act;
  int            t_g;
  bit            m_gnt;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            streak;
  bit            ack_if;
  bit            ack_d;
  bit            hold_d;
  bit            rnd;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit            fl;
    bit            en;
    bit            ak;
    logic [DW-1:0] rd;
    fl = act && cyc > t_g && cyc <= t_g + L + 1;
    en = act && cyc == t_g + 1;
    ak = act && cyc == t_g + 1 + L;
    rd = ref_mem[m_addr[7:0]];
    chk("busy", 32'(bus.busy), 32'(fl));
    chk("mem_en", 32'(bus.mem_en), 32'(en));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("mem_wr", 32'(bus.mem_wr), 32'(m_wr));
    if (en && m_wr)
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    chk("if_ack", 32'(bus.if_ack), 32'(ak && !m_gnt));
    chk("d_ack", 32'(bus.d_ack), 32'(ak && m_gnt));
    chk("if_rdata", 32'(bus.if_rdata),
        32'((ak && !m_gnt) ? rd : '0));
    chk("d_rdata", 32'(bus.d_rdata),
        32'((ak && m_gnt && !m_wr) ? rd : '0));
  endtask

  task automatic commit();
    bit fl;
    bit en;
    bit ak;
    bit take_d;
    fl = act && cyc > t_g && cyc <= t_g + L + 1;
    en = act && cyc == t_g + 1;
    ak = act && cyc == t_g + 1 + L;
    ack_if = ak && !m_gnt;
    ack_d  = ak && m_gnt;
    if (en && m_wr) ref_mem[m_addr[7:0]] = m_wdata;
    if (rst) begin
      act     = 1'b0;
      m_gnt   = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      streak  = 0;
    end else if (!fl && (bus.if_req || bus.d_req)) begin
      take_d  = bus.d_req && !(bus.if_req && streak == SM);
      m_gnt   = take_d;
      m_wr    = take_d && bus.d_wr;
      m_addr  = take_d ? bus.d_addr : bus.if_addr;
      m_wdata = bus.d_wdata;
      if (take_d && bus.if_req)
        streak = (streak < SM) ? streak + 1 : SM;
      else
        streak = 0;
      act = 1'b1;
      t_g = cyc;
    end
  endtask

  task automatic new_d();
    bus.d_addr  = AW'($urandom);
    bus.d_wdata = DW'($urandom);
    bus.d_wr    = 1'($urandom);
  endtask

  task automatic drive();
    if (bus.if_req && ack_if) begin
      if (rnd && $urandom_range(3) == 0)
        bus.if_addr = AW'($urandom);
      else
        bus.if_req = 1'b0;
    end else if (!bus.if_req && rnd) begin
      bus.if_addr = AW'($urandom);
      bus.if_req  = ($urandom_range(2) == 0);
    end
    if (bus.d_req && ack_d) begin
      if (hold_d || (rnd && $urandom_range(3) == 0))
        new_d();
      else
        bus.d_req = 1'b0;
    end else if (!bus.d_req && rnd) begin
      new_d();
      bus.d_req = ($urandom_range(2) == 0);
    end
  endtask

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      commit();
      @(posedge clk);
      #1;
      cyc++;
      drive();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    cyc = 0; act = 0; t_g = 0; m_gnt = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; streak = 0;
    ack_if = 0; ack_d = 0; hold_d = 0; rnd = 0;
    n_chk = 0; n_fail = 0;
    @(posedge clk);
    #1;
    cycle(2);
    rst = 1'b0;

    // single fetch from 0x0010
    bus.if_addr = 16'h0010;
    bus.if_req  = 1'b1;
    cycle(8);

    // fetch and load in the same cycle
    bus.if_addr = 16'h0020;
    bus.if_req  = 1'b1;
    bus.d_addr  = 16'h0200;
    bus.d_wr    = 1'b0;
    bus.d_req   = 1'b1;
    cycle(14);

    // data re-requests back to back while fetch waits
    hold_d      = 1'b1;
    bus.if_addr = 16'h0030;
    bus.if_req  = 1'b1;
    bus.d_addr  = 16'h0300;
    bus.d_wr    = 1'b0;
    bus.d_req   = 1'b1;
    cycle(30);
    hold_d = 1'b0;
    cycle(10);

    // store then load the same word
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'h1234;
    bus.d_wr    = 1'b1;
    bus.d_req   = 1'b1;
    cycle(7);
    bus.d_wr  = 1'b0;
    bus.d_req = 1'b1;
    cycle(7);

    // reset while waiting on memory
    bus.if_addr = 16'h0050;
    bus.if_req  = 1'b1;
    cycle(3);
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
    cycle(10);

    // two-cycle reset with both requesters active
    bus.d_addr  = 16'h0060;
    bus.d_wdata = 16'hBEEF;
    bus.d_wr    = 1'b1;
    bus.d_req   = 1'b1;
    bus.if_addr = 16'h0070;
    bus.if_req  = 1'b1;
    cycle(2);
    rst = 1'b1;
    cycle(2);
    rst = 1'b0;
    cycle(20);

    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      cycle(1);
    end
    rst = 1'b0;
    rnd = 1'b0;
    cycle(16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
